// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL constants and the natural byte-lane mask helper for a 32-bit bus.
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
    localparam int         MASK_W          = 4;

    // Lanes covered by an aligned transfer of 2**size bytes starting at addr_lo.
    function automatic logic [MASK_W-1:0] natural_mask(input logic [1:0] size,
                                                       input logic [1:0] addr_lo);
        logic [MASK_W-1:0] m;
        case (size)
            2'd0:    m = 4'b0001 << addr_lo;
            2'd1:    m = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tl_ul_ram_sp.sv
// Single-port synchronous RAM with per-byte write enables; read data holds while not enabled.
module tl_ul_ram_sp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LANES = DATA_W / 8;

    // One byte-wide array per lane so each lane maps onto its own write enable.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rdata_q;

        always_ff @(posedge clock) begin
            if (en) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
                rdata_q <= mem[addr];
            end
        end

        assign rdata[gi*8 +: 8] = rdata_q;
    end

endmodule

// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL slave terminating A/D on a byte-enabled SRAM: A-fire (RAM access) -> R -> D register.
module tl_ul_ram_responder
    import tl_ul_pkg::*;
#(
    parameter int               ADDR_W     = 30,
    parameter int               DATA_W     = 32,
    parameter int               SRC_W      = 7,
    parameter int               SIZE_W     = 4,
    parameter int               DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE      = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [SIZE_W-1:0] a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [MASK_W-1:0] a_mask,
    input  logic [DATA_W-1:0] a_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        d_opcode,
    output logic [1:0]        d_param,
    output logic [SIZE_W-1:0] d_size,
    output logic [SRC_W-1:0]  d_source,
    output logic              d_sink,
    output logic              d_denied,
    output logic [DATA_W-1:0] d_data,
    output logic              d_corrupt
);

    logic              a_fire, r_adv;
    logic              legal, is_put, op_ok, size_ok, range_ok, align_ok, mask_ok;
    logic [MASK_W-1:0] nat_mask, ram_we;
    logic [ADDR_W:0]   offset;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_ok;

    logic              r_valid_q, r_valid_d, r_denied_q, r_denied_d;
    logic [2:0]        r_opcode_q, r_opcode_d;
    logic [SIZE_W-1:0] r_size_q, r_size_d;
    logic [SRC_W-1:0]  r_source_q, r_source_d;

    logic              d_valid_q, d_valid_d, d_denied_q, d_denied_d, d_corrupt_q, d_corrupt_d;
    logic [2:0]        d_opcode_q, d_opcode_d;
    logic [SIZE_W-1:0] d_size_q, d_size_d;
    logic [SRC_W-1:0]  d_source_q, d_source_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;

    assign r_adv   = r_valid_q & (~d_valid_q | d_ready);
    assign a_ready = ~r_valid_q | r_adv;
    assign a_fire  = a_valid & a_ready;

    // A borrow out of the subtraction marks addresses below BASE.
    assign offset    = {1'b0, a_address} - {1'b0, BASE};
    assign unused_ok = ^{a_param, offset[1:0]};

    always_comb begin
        nat_mask = natural_mask(a_size[1:0], a_address[1:0]);
        op_ok    = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL) || (a_opcode == GET);
        is_put   = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
        size_ok  = (a_size <= SIZE_W'(2));
        range_ok = ~offset[ADDR_W] && (offset[ADDR_W-1:DEPTH_LOG2+2] == '0);
        case (a_size[1:0])
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = ~a_address[0];
            default: align_ok = (a_address[1:0] == 2'b00);
        endcase
        case (a_opcode)
            PUT_FULL:    mask_ok = (a_mask == nat_mask);
            PUT_PARTIAL: mask_ok = ((a_mask & ~nat_mask) == '0);
            default:     mask_ok = 1'b1;
        endcase
        legal  = op_ok & size_ok & range_ok & align_ok & mask_ok;
        ram_we = (a_fire & legal & is_put) ? a_mask : '0;
    end

    tl_ul_ram_sp #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clock (clock),
        .en    (a_fire),
        .we    (ram_we),
        .addr  (offset[DEPTH_LOG2+1:2]),
        .wdata (a_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        r_valid_d  = r_valid_q;
        r_opcode_d = r_opcode_q;
        r_size_d   = r_size_q;
        r_source_d = r_source_q;
        r_denied_d = r_denied_q;
        if (a_fire) begin
            r_valid_d  = 1'b1;
            r_opcode_d = (a_opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
            r_size_d   = a_size;
            r_source_d = a_source;
            r_denied_d = ~legal;
        end else if (r_adv) begin
            r_valid_d  = 1'b0;
        end
    end

    // RAM read data is only sampled here, on the cycle R hands over to D.
    always_comb begin
        d_valid_d   = d_valid_q;
        d_opcode_d  = d_opcode_q;
        d_size_d    = d_size_q;
        d_source_d  = d_source_q;
        d_denied_d  = d_denied_q;
        d_data_d    = d_data_q;
        d_corrupt_d = d_corrupt_q;
        if (r_adv) begin
            d_valid_d   = 1'b1;
            d_opcode_d  = r_opcode_q;
            d_size_d    = r_size_q;
            d_source_d  = r_source_q;
            d_denied_d  = r_denied_q;
            d_data_d    = (r_opcode_q == ACCESS_ACK_DATA && !r_denied_q) ? ram_rdata : '0;
            d_corrupt_d = r_denied_q & (r_opcode_q == ACCESS_ACK_DATA);
        end else if (d_ready) begin
            d_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_q   <= 1'b0;
            r_opcode_q  <= '0;
            r_size_q    <= '0;
            r_source_q  <= '0;
            r_denied_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_data_q    <= '0;
            d_corrupt_q <= 1'b0;
        end else begin
            r_valid_q   <= r_valid_d;
            r_opcode_q  <= r_opcode_d;
            r_size_q    <= r_size_d;
            r_source_q  <= r_source_d;
            r_denied_q  <= r_denied_d;
            d_valid_q   <= d_valid_d;
            d_opcode_q  <= d_opcode_d;
            d_size_q    <= d_size_d;
            d_source_q  <= d_source_d;
            d_denied_q  <= d_denied_d;
            d_data_q    <= d_data_d;
            d_corrupt_q <= d_corrupt_d;
        end
    end

    assign d_valid   = d_valid_q;
    assign d_opcode  = d_opcode_q;
    assign d_param   = 2'b00;
    assign d_size    = d_size_q;
    assign d_source  = d_source_q;
    assign d_sink    = 1'b0;
    assign d_denied  = d_denied_q;
    assign d_data    = d_data_q;
    assign d_corrupt = d_corrupt_q;

endmodule
